wt_mem_arbiter: RTL and testbench
=================================

Name: wt_mem_arbiter

Overview:
Shares one memory-side request port between the I$ and D$ request channels of the write-through cache subsystem. It sits between the two caches and the memory adapter (AXI or L15).
- Requests are arbitrated round-robin.
- Each request is tagged with its source.
- Responses are routed back to the source that issued them.
- A per-source outstanding-transaction limit is enforced, so neither cache can monopolise the adapter.

Parameters:
ReqWidth, 128, width of the opaque request payload (packed icache_req_t / dcache_req_t, zero-extended to the common width)
MaxOutIcache, 2, maximum outstanding I$ transactions
MaxOutDcache, 8, maximum outstanding D$ transactions (matches DCACHE_MAX_TX)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
icache_data_req_i  in  1  I$ request; held with stable payload until ack
icache_data_ack_o  out  1  I$ request accepted (1-cycle pulse)
icache_data_i  in  ReqWidth  I$ request payload
dcache_data_req_i  in  1  D$ request; held with stable payload until ack
dcache_data_ack_o  out  1  D$ request accepted (1-cycle pulse)
dcache_data_i  in  ReqWidth  D$ request payload
mem_req_o  out  1  request to adapter; held until mem_ack_i
mem_ack_i  in  1  adapter accepted request
mem_data_o  out  ReqWidth  payload of granted source
mem_src_o  out  1  source tag: 0=I$, 1=D$
mem_rtrn_vld_i  in  1  response valid from adapter
mem_rtrn_src_i  in  1  source tag of response
icache_rtrn_vld_o  out  1  response valid to I$
dcache_rtrn_vld_o  out  1  response valid to D$
busy_o  out  1  any transaction granted or outstanding
err_o  out  1  sticky: response for a source with zero outstanding

Behaviour:
- Single clock. Reset is asynchronous and active-low, on clk_i/rst_ni.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - both counters 0;
  - rr_last_q=1, so I$ wins the first tie.
- Eligibility: src_elig[s] = req[s] && (cnt[s] < MaxOut[s]).
- Pick: if both are eligible, choose the source != rr_last_q; otherwise choose the single eligible source.
- FSM has states IDLE, GNT_I, GNT_D.
  - IDLE -> GNT_x on the registered pick. mem_req_o rises the cycle after the requester's req (1-cycle latency).
  - GNT_x: mem_req_o=1, mem_data_o = payload of x, mem_src_o = x. The payload mux is driven only by the state register.
  - On mem_ack_i in GNT_x:
    - assert x_data_ack_o combinationally in the same cycle;
    - cnt[x]++ and rr_last_q <= x;
    - re-arbitrate in the same cycle with req[x] masked. Next state is GNT_other if the other source is eligible (using post-increment counts), else IDLE.
  - Back-to-back alternate grants therefore sustain one transfer per cycle.
  - No mem_ack_i: stay in GNT_x. mem_req_o is never deasserted before ack.
- Return path:
  - x_rtrn_vld_o = mem_rtrn_vld_i && (mem_rtrn_src_i == x), purely combinational, zero latency. Payload goes from adapter to caches directly, not through this block.
  - Each return decrements cnt[x].
  - Ack and return on the same source in the same cycle leave cnt[x] unchanged.
  - A return with cnt[x]==0: counter stays 0 (no underflow), err_o <= 1 sticky until reset.
- Counter width is $clog2(MaxOut+1). A counter at MaxOut blocks new grants for that source only.
- busy_o = (state != IDLE) || (cnt_i != 0) || (cnt_d != 0).
- Reset mid-grant: everything returns to reset values immediately. In-flight responses after reset set err_o; the system must quiesce before reset.

Decomposition:
- Put MaxOut defaults and the source enum (SRC_ICACHE=0, SRC_DCACHE=1) in wt_cache_pkg.
- One natural sub-module: wt_out_cnt, a saturating up/down outstanding counter with limit compare and underflow flag, instantiated twice.

Test Plan:
- Single I$ req at cycle 0, mem_ack_i at cycle 3 -> mem_req_o=1 on cycles 1–3 with mem_src_o=0; icache_data_ack_o pulses at cycle 3; busy_o=1.
- Both req at cycle 0, mem_ack_i held 1 -> grants I$ (cycle 1) then D$ (cycle 2) back-to-back; rr_last_q=D$ afterwards.
- Both req continuously, mem_ack_i=1, no returns -> grants alternate I,D,I,D; after 2 I$ acks only D$ is granted until the 8th D$ ack; then mem_req_o=0.
- cnt_d=8 at limit, D$ return and no ack -> cnt_d=7; D$ is granted on the following cycle.
- cnt_i=1, I$ ack and I$ return in the same cycle -> cnt_i stays 1; icache_rtrn_vld_o=1.
- Return with src=1 when cnt_d=0 -> dcache_rtrn_vld_o=1, err_o=1 from the next cycle onward; asserting rst_ni=0 mid-GNT_D clears mem_req_o and err_o asynchronously.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared types and defaults for the write-through cache memory-side arbitration.
package wt_cache_pkg;

  localparam int unsigned REQ_WIDTH      = 128;
  localparam int unsigned MAX_OUT_ICACHE = 2;
  localparam int unsigned MAX_OUT_DCACHE = 8;

  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wt_out_cnt.sv
// Outstanding-transaction counter for one source: saturating up/down count,
// limit compare, and underflow detection for returns that have no owner.
module wt_out_cnt #(
  parameter  int unsigned MaxOut   = 8,
  localparam int unsigned CntWidth = $clog2(MaxOut + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                avail_o,
  output logic                underflow_o
);

  logic [CntWidth-1:0] cnt_q;

  assign cnt_o       = cnt_q;
  assign avail_o     = cnt_q < CntWidth'(MaxOut);
  assign underflow_o = dec_i && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && avail_o) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end else if (dec_i && !inc_i && !underflow_o) begin
      cnt_q <= cnt_q - CntWidth'(1);
    end
  end

endmodule

// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter sharing one memory-side request port between I$ and D$,
// with per-source outstanding limits and source-tagged response routing.
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned ReqWidth     = REQ_WIDTH,
  parameter int unsigned MaxOutIcache = MAX_OUT_ICACHE,
  parameter int unsigned MaxOutDcache = MAX_OUT_DCACHE
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                icache_data_req_i,
  output logic                icache_data_ack_o,
  input  logic [ReqWidth-1:0] icache_data_i,
  input  logic                dcache_data_req_i,
  output logic                dcache_data_ack_o,
  input  logic [ReqWidth-1:0] dcache_data_i,
  output logic                mem_req_o,
  input  logic                mem_ack_i,
  output logic [ReqWidth-1:0] mem_data_o,
  output logic                mem_src_o,
  input  logic                mem_rtrn_vld_i,
  input  logic                mem_rtrn_src_i,
  output logic                icache_rtrn_vld_o,
  output logic                dcache_rtrn_vld_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned CntIWidth = $clog2(MaxOutIcache + 1);
  localparam int unsigned CntDWidth = $clog2(MaxOutDcache + 1);

  arb_state_e           state_q, state_d;
  src_e                 rr_last_q, rr_last_d;
  logic [CntIWidth-1:0] cnt_i;
  logic [CntDWidth-1:0] cnt_d;
  logic                 avail_i, avail_d;
  logic                 elig_i, elig_d;
  logic                 underflow_i, underflow_d;
  logic                 err_q;

  // Responses bypass the arbiter state entirely: zero-latency routing by tag.
  assign icache_rtrn_vld_o = mem_rtrn_vld_i && (mem_rtrn_src_i == SRC_ICACHE);
  assign dcache_rtrn_vld_o = mem_rtrn_vld_i && (mem_rtrn_src_i == SRC_DCACHE);

  assign elig_i = icache_data_req_i && avail_i;
  assign elig_d = dcache_data_req_i && avail_d;

  wt_out_cnt #(.MaxOut(MaxOutIcache)) u_cnt_icache (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .inc_i      (icache_data_ack_o),
    .dec_i      (icache_rtrn_vld_o),
    .cnt_o      (cnt_i),
    .avail_o    (avail_i),
    .underflow_o(underflow_i)
  );

  wt_out_cnt #(.MaxOut(MaxOutDcache)) u_cnt_dcache (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .inc_i      (dcache_data_ack_o),
    .dec_i      (dcache_rtrn_vld_o),
    .cnt_o      (cnt_d),
    .avail_o    (avail_d),
    .underflow_o(underflow_d)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d           = state_q;
    rr_last_d         = rr_last_q;
    mem_req_o         = 1'b0;
    mem_data_o        = '0;
    mem_src_o         = SRC_ICACHE;
    icache_data_ack_o = 1'b0;
    dcache_data_ack_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig_i && elig_d) begin
          state_d = (rr_last_q == SRC_ICACHE) ? GNT_D : GNT_I;
        end else if (elig_i) begin
          state_d = GNT_I;
        end else if (elig_d) begin
          state_d = GNT_D;
        end
      end
      // On ack the granted source is masked; only the other one can follow.
      GNT_I: begin
        mem_req_o  = 1'b1;
        mem_data_o = icache_data_i;
        mem_src_o  = SRC_ICACHE;
        if (mem_ack_i) begin
          icache_data_ack_o = 1'b1;
          rr_last_d         = SRC_ICACHE;
          state_d           = elig_d ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        mem_req_o  = 1'b1;
        mem_data_o = dcache_data_i;
        mem_src_o  = SRC_DCACHE;
        if (mem_ack_i) begin
          dcache_data_ack_o = 1'b1;
          rr_last_d         = SRC_DCACHE;
          state_d           = elig_i ? GNT_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rr_last_q resets to D$ so that I$ wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_last_q <= SRC_DCACHE;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      if (underflow_i || underflow_d) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o  = err_q;
  assign busy_o = (state_q != IDLE) || (cnt_i != '0) || (cnt_d != '0);

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Self-checking bench for wt_mem_arbiter: grant order and payloads are checked
// through a scoreboard queue; timing, limits and return routing inline.
module tb_wt_mem_arbiter;
  import wt_cache_pkg::*;

  localparam int W = 128;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         icache_data_req_i, icache_data_ack_o;
  logic [W-1:0] icache_data_i;
  logic         dcache_data_req_i, dcache_data_ack_o;
  logic [W-1:0] dcache_data_i;
  logic         mem_req_o, mem_ack_i;
  logic [W-1:0] mem_data_o;
  logic         mem_src_o;
  logic         mem_rtrn_vld_i, mem_rtrn_src_i;
  logic         icache_rtrn_vld_o, dcache_rtrn_vld_o;
  logic         busy_o, err_o;

  typedef struct {
    logic         src;
    logic [W-1:0] data;
  } grant_t;

  grant_t exp_q[$];
  grant_t mon_exp;
  int     n_checks = 0;
  int     n_errors = 0;

  wt_mem_arbiter dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .icache_data_req_i(icache_data_req_i),
    .icache_data_ack_o(icache_data_ack_o),
    .icache_data_i    (icache_data_i),
    .dcache_data_req_i(dcache_data_req_i),
    .dcache_data_ack_o(dcache_data_ack_o),
    .dcache_data_i    (dcache_data_i),
    .mem_req_o        (mem_req_o),
    .mem_ack_i        (mem_ack_i),
    .mem_data_o       (mem_data_o),
    .mem_src_o        (mem_src_o),
    .mem_rtrn_vld_i   (mem_rtrn_vld_i),
    .mem_rtrn_src_i   (mem_rtrn_src_i),
    .icache_rtrn_vld_o(icache_rtrn_vld_o),
    .dcache_rtrn_vld_o(dcache_rtrn_vld_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every accepted transfer must match the next expected grant.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && mem_req_o === 1'b1 && mem_ack_i === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL grant_unexpected: src=%0d granted, no grant expected", mem_src_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mem_src_o !== mon_exp.src || mem_data_o !== mon_exp.data) begin
          n_errors++;
          $display("FAIL grant_order: got src=%0d data=%h, expected src=%0d data=%h",
                   mem_src_o, mem_data_o, mon_exp.src, mon_exp.data);
        end
        n_checks++;
        if ({icache_data_ack_o, dcache_data_ack_o} !== (mon_exp.src ? 2'b01 : 2'b10)) begin
          n_errors++;
          $display("FAIL grant_ack: got i_ack=%b d_ack=%b for expected src=%0d",
                   icache_data_ack_o, dcache_data_ack_o, mon_exp.src);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    icache_data_req_i = 1'b0;
    dcache_data_req_i = 1'b0;
    mem_ack_i         = 1'b0;
    mem_rtrn_vld_i    = 1'b0;
    mem_rtrn_src_i    = 1'b0;
  endtask

  task automatic push_grant(input logic src, input logic [W-1:0] data);
    grant_t g;
    g.src  = src;
    g.data = data;
    exp_q.push_back(g);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    exp_q.delete();
  endtask

  // Requester model: each source keeps asking until n requests were acked.
  task automatic drive_reqs(input int n_i, input int n_d, input int cycles,
                            output int left_i, output int left_d);
    left_i = n_i;
    left_d = n_d;
    for (int c = 0; c < cycles; c++) begin
      icache_data_req_i = (left_i > 0);
      dcache_data_req_i = (left_d > 0);
      @(negedge clk_i);
      if (icache_data_ack_o) left_i--;
      if (dcache_data_ack_o) left_d--;
      step();
    end
    icache_data_req_i = 1'b0;
    dcache_data_req_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    icache_data_i = '0;
    dcache_data_i = '0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({mem_req_o, mem_src_o, icache_data_ack_o, dcache_data_ack_o, icache_rtrn_vld_o,
         dcache_rtrn_vld_o, busy_o, err_o} !== 8'h00 || mem_data_o !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got req=%b src=%b acks=%b%b rtrn=%b%b busy=%b err=%b, expected all 0",
               mem_req_o, mem_src_o, icache_data_ack_o, dcache_data_ack_o,
               icache_rtrn_vld_o, dcache_rtrn_vld_o, busy_o, err_o);
    end
    step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got req=%b busy=%b, expected 0 0", mem_req_o, busy_o);
    end
    step();
  endtask

  task automatic test_single_icache();
    logic [W-1:0] p;
    do_reset();
    p = {$urandom, $urandom, $urandom, $urandom};
    icache_data_i     = p;
    icache_data_req_i = 1'b1;
    push_grant(SRC_ICACHE, p);
    @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL single_latency: mem_req_o=%b in request cycle, expected 0", mem_req_o);
    end
    step();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) mem_ack_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (mem_req_o !== 1'b1 || mem_src_o !== 1'b0 || mem_data_o !== p || busy_o !== 1'b1) begin
        n_errors++;
        $display("FAIL single_hold c%0d: got req=%b src=%b busy=%b data=%h, expected 1 0 1 %h",
                 c, mem_req_o, mem_src_o, busy_o, mem_data_o, p);
      end
      n_checks++;
      if (icache_data_ack_o !== (c == 3)) begin
        n_errors++;
        $display("FAIL single_ack c%0d: icache_data_ack_o=%b, expected %b", c, icache_data_ack_o, c == 3);
      end
      step();
    end
    idle_inputs();
    @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL single_outstanding: got req=%b busy=%b, expected 0 1", mem_req_o, busy_o);
    end
    step();
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_src_i = SRC_ICACHE;
    @(negedge clk_i);
    n_checks++;
    if ({icache_rtrn_vld_o, dcache_rtrn_vld_o} !== 2'b10) begin
      n_errors++;
      $display("FAIL single_rtrn_route: got i=%b d=%b, expected 1 0", icache_rtrn_vld_o, dcache_rtrn_vld_o);
    end
    step();
    idle_inputs();
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL single_drain: got busy=%b err=%b pending=%0d, expected 0 0 0", busy_o, err_o, exp_q.size());
    end
    step();
  endtask

  task automatic test_back_to_back();
    int li, ld;
    do_reset();
    icache_data_i = {$urandom, $urandom, $urandom, $urandom};
    dcache_data_i = {$urandom, $urandom, $urandom, $urandom};
    mem_ack_i = 1'b1;
    // Tie from reset goes to I$, then D$ follows with no idle cycle.
    push_grant(SRC_ICACHE, icache_data_i);
    push_grant(SRC_DCACHE, dcache_data_i);
    drive_reqs(1, 1, 3, li, ld);
    n_checks++;
    if (li != 0 || ld != 0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_two_cycles: left_i=%0d left_d=%0d pending=%0d, expected 0 0 0", li, ld, exp_q.size());
    end
    mem_ack_i      = 1'b0;
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_src_i = SRC_ICACHE;
    step();
    mem_rtrn_src_i = SRC_DCACHE;
    step();
    idle_inputs();
    mem_ack_i = 1'b1;
    // A lone I$ grant moves the round-robin pointer, so the next tie goes to D$.
    push_grant(SRC_ICACHE, icache_data_i);
    drive_reqs(1, 0, 3, li, ld);
    push_grant(SRC_DCACHE, dcache_data_i);
    push_grant(SRC_ICACHE, icache_data_i);
    drive_reqs(1, 1, 4, li, ld);
    n_checks++;
    if (li != 0 || ld != 0 || exp_q.size() != 0 || err_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rr_pointer: left_i=%0d left_d=%0d pending=%0d err=%b, expected 0 0 0 0",
               li, ld, exp_q.size(), err_o);
    end
    idle_inputs();
  endtask

  task automatic test_limits();
    int li, ld;
    do_reset();
    icache_data_i = {$urandom, $urandom, $urandom, $urandom};
    dcache_data_i = {$urandom, $urandom, $urandom, $urandom};
    mem_ack_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push_grant(SRC_ICACHE, icache_data_i);
      push_grant(SRC_DCACHE, dcache_data_i);
    end
    for (int k = 0; k < 6; k++) push_grant(SRC_DCACHE, dcache_data_i);
    drive_reqs(5, 10, 24, li, ld);
    n_checks++;
    if (li != 3 || ld != 2 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL limit_counts: left_i=%0d left_d=%0d pending=%0d, expected 3 2 0", li, ld, exp_q.size());
    end
    icache_data_req_i = 1'b1;
    dcache_data_req_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
        n_errors++;
        $display("FAIL limit_block c%0d: got req=%b busy=%b, expected 0 1", c, mem_req_o, busy_o);
      end
      step();
    end
    // One D$ return frees a slot for D$ only; I$ stays at its limit.
    mem_ack_i         = 1'b0;
    icache_data_req_i = 1'b0;
    mem_rtrn_vld_i    = 1'b1;
    mem_rtrn_src_i    = SRC_DCACHE;
    @(negedge clk_i);
    n_checks++;
    if (dcache_rtrn_vld_o !== 1'b1 || icache_rtrn_vld_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL limit_return: got d_rtrn=%b i_rtrn=%b req=%b, expected 1 0 0",
               dcache_rtrn_vld_o, icache_rtrn_vld_o, mem_req_o);
    end
    step();
    mem_rtrn_vld_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL limit_pick_cycle: mem_req_o=%b, expected 0", mem_req_o);
    end
    step();
    mem_ack_i = 1'b1;
    push_grant(SRC_DCACHE, dcache_data_i);
    @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_src_o !== 1'b1 || dcache_data_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL limit_release: got req=%b src=%b d_ack=%b, expected 1 1 1",
               mem_req_o, mem_src_o, dcache_data_ack_o);
    end
    step();
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL limit_refull: got req=%b pending=%0d, expected 0 0", mem_req_o, exp_q.size());
    end
    step();
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    int li, ld;
    do_reset();
    icache_data_i = {$urandom, $urandom, $urandom, $urandom};
    mem_ack_i = 1'b1;
    push_grant(SRC_ICACHE, icache_data_i);
    drive_reqs(1, 0, 3, li, ld);
    mem_ack_i         = 1'b0;
    icache_data_i     = {$urandom, $urandom, $urandom, $urandom};
    icache_data_req_i = 1'b1;
    push_grant(SRC_ICACHE, icache_data_i);
    step();
    mem_ack_i      = 1'b1;
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_src_i = SRC_ICACHE;
    @(negedge clk_i);
    n_checks++;
    if (icache_rtrn_vld_o !== 1'b1 || icache_data_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL same_cycle_pulse: got i_rtrn=%b i_ack=%b, expected 1 1", icache_rtrn_vld_o, icache_data_ack_o);
    end
    step();
    idle_inputs();
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL same_cycle_count: got busy=%b req=%b, expected 1 0", busy_o, mem_req_o);
    end
    step();
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_src_i = SRC_ICACHE;
    step();
    idle_inputs();
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL same_cycle_drain: got busy=%b err=%b pending=%0d, expected 0 0 0",
               busy_o, err_o, exp_q.size());
    end
    step();
  endtask

  task automatic test_underflow_err();
    do_reset();
    dcache_data_i  = {$urandom, $urandom, $urandom, $urandom};
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_src_i = SRC_DCACHE;
    @(negedge clk_i);
    n_checks++;
    if ({icache_rtrn_vld_o, dcache_rtrn_vld_o} !== 2'b01 || err_o !== 1'b0) begin
      n_errors++;
      $display("FAIL err_return: got i=%b d=%b err=%b, expected 0 1 0",
               icache_rtrn_vld_o, dcache_rtrn_vld_o, err_o);
    end
    step();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
        n_errors++;
        $display("FAIL err_sticky c%0d: got err=%b busy=%b, expected 1 0", c, err_o, busy_o);
      end
      step();
    end
    dcache_data_req_i = 1'b1;
    step();
    @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_src_o !== 1'b1 || mem_data_o !== dcache_data_i) begin
      n_errors++;
      $display("FAIL err_gnt_d: got req=%b src=%b data=%h, expected 1 1 %h",
               mem_req_o, mem_src_o, mem_data_o, dcache_data_i);
    end
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got req=%b err=%b busy=%b, expected 0 0 0", mem_req_o, err_o, busy_o);
    end
    idle_inputs();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_icache();
    test_back_to_back();
    test_limits();
    test_same_cycle();
    test_underflow_err();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
